// File: rtl/mtx_pkg.sv
// mtx_pkg: shared definitions for the mtx matrix channel paths.
//   MTX_DROP_CNT_W   - width of the dropped-beat counter
//   MTX_DROP_CNT_SAT - value at which the dropped-beat counter stops counting
//   mtx_ch_t         - channel id type for the default channel count, shared
//                      with the merge path
package mtx_pkg;

  localparam int MTX_DROP_CNT_W = 16;
  localparam logic [MTX_DROP_CNT_W-1:0] MTX_DROP_CNT_SAT = 16'hFFFF;

  localparam int MTX_NUM_CH_DEF = 32;
  localparam int MTX_CH_W       = $clog2(MTX_NUM_CH_DEF);

  typedef logic [MTX_CH_W-1:0] mtx_ch_t;

endpackage

// File: rtl/mtx_dist_if.sv
// mtx_dist_if: tagged input stream plus per-channel output streams of the
// channel distributor.
//   in_valid/in_ready/in_ch/in_data      - single tagged input stream
//   out_valid/out_ready/out_data         - NUM_CH output streams, channel k
//                                          data at [k*DATA_WIDTH +: DATA_WIDTH]
//
// Handshake rule for every stream here: a beat transfers on a rising clk edge
// where valid && ready. A source holding valid high keeps its payload stable
// until the transfer; ready may depend combinationally on the other side.
//
// Modports:
//   master - the side that produces input beats and consumes output beats
//   slave  - the distributor itself
interface mtx_dist_if #(
  parameter int NUM_CH     = 32,
  parameter int DATA_WIDTH = 32
);

  localparam int CH_W = $clog2(NUM_CH);

  logic                         in_valid;
  logic                         in_ready;
  logic [CH_W-1:0]              in_ch;
  logic [DATA_WIDTH-1:0]        in_data;
  logic [NUM_CH-1:0]            out_valid;
  logic [NUM_CH-1:0]            out_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_ch, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_ch, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/mtx_ch_buf.sv
// mtx_ch_buf: one-entry valid/ready holding buffer for a single channel.
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - write load_data this cycle (caller only asserts when ready)
//   load_data  - payload to capture
//   drain      - downstream ready for this channel
//   vld, data  - buffered beat presented downstream
//   ready      - buffer can take a beat this cycle (empty or draining now)
module mtx_ch_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  drain,
  output logic                  vld,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  ready
);

  // Accepting while draining gives one beat per cycle through the buffer.
  assign ready = !vld || drain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (load) begin
      // A load wins over a same-cycle drain: the old beat leaves, the new
      // one stays.
      vld  <= 1'b1;
      data <= load_data;
    end else if (vld && drain) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/mtx_dist.sv
// mtx_dist: steers a tagged input stream into NUM_CH per-channel outputs,
// each behind its own one-entry buffer so a stalled channel only blocks beats
// addressed to it. Beats tagged with a channel id >= NUM_CH are accepted,
// discarded and counted.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - mtx_dist_if slave: tagged input and per-channel outputs
//   cnt_clr    - synchronous clear of drop_cnt (wins over a same-cycle drop)
//   drop_cnt   - saturating count of discarded beats
//   drop_pulse - one-cycle pulse, registered, for each discarded beat
module mtx_dist
  import mtx_pkg::*;
#(
  parameter int NUM_CH     = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mtx_dist_if.slave                 bus,
  input  logic                      cnt_clr,
  output logic [MTX_DROP_CNT_W-1:0] drop_cnt,
  output logic                      drop_pulse
);

  localparam int CH_W = $clog2(NUM_CH);

  logic              in_range;
  logic              drop;
  logic [NUM_CH-1:0] ch_ready;
  logic [NUM_CH-1:0] ch_load;

  // Only a non-power-of-two channel count leaves unused ids.
  generate
    if (NUM_CH == (1 << CH_W)) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
      assign in_range = (bus.in_ch <= LAST_CH);
    end
  endgenerate

  // Combinational from out_ready so a draining buffer can refill in the same
  // cycle. Out-of-range beats are always taken so they never block the stream.
  assign bus.in_ready = in_range ? ch_ready[bus.in_ch] : 1'b1;
  assign drop         = bus.in_valid && !in_range;

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign ch_load[k] = bus.in_valid && in_range && ch_ready[k] &&
                          (bus.in_ch == CH_W'(k));

      mtx_ch_buf #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ch_load[k]),
        .load_data (bus.in_data),
        .drain     (bus.out_ready[k]),
        .vld       (bus.out_valid[k]),
        .data      (bus.out_data[k*DATA_WIDTH +: DATA_WIDTH]),
        .ready     (ch_ready[k])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      if (cnt_clr) begin
        drop_cnt <= '0;
      end else if (drop && (drop_cnt != MTX_DROP_CNT_SAT)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mtx_dist.sv
// tb_mtx_dist: self-checking bench for mtx_dist with 20 channels so that
// channel ids 20..31 exercise the drop path.
module tb_mtx_dist;

  localparam int NCH     = 20;
  localparam int DW      = 32;
  localparam int TIMEOUT = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cnt_clr;
  logic [15:0] drop_cnt;
  logic        drop_pulse;

  mtx_dist_if #(.NUM_CH(NCH), .DATA_WIDTH(DW)) bus ();

  mtx_dist #(
    .NUM_CH     (NCH),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cnt_clr    (cnt_clr),
    .drop_cnt   (drop_cnt),
    .drop_pulse (drop_pulse)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[NCH][$];

  // Drop counter / pulse reference: a drop is any valid beat tagged >= NCH.
  logic [15:0] m_cnt;
  logic        m_pulse;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= '0;
      m_pulse <= 1'b0;
    end else begin
      m_pulse <= bus.in_valid && (int'(bus.in_ch) >= NCH);
      if (cnt_clr) m_cnt <= '0;
      else if (bus.in_valid && (int'(bus.in_ch) >= NCH) && (m_cnt != 16'hFFFF))
        m_cnt <= m_cnt + 16'd1;
    end
  end

  // Output monitor: a valid channel must show the oldest expected beat; it
  // is retired when the handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("drop_pulse_model", {31'd0, drop_pulse}, {31'd0, m_pulse});
      chk("drop_cnt_model", {16'd0, drop_cnt}, {16'd0, m_cnt});
      for (int k = 0; k < NCH; k++) begin
        if (bus.out_valid[k]) begin
          if (exp_q[k].size() == 0) begin
            chk($sformatf("spurious_valid_ch%0d", k), 32'd1, 32'd0);
          end else begin
            chk($sformatf("out_data_ch%0d", k), bus.out_data[k*DW +: DW], exp_q[k][0]);
            if (bus.out_ready[k]) void'(exp_q[k].pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int ch, input logic [DW-1:0] d, output int stalls);
    stalls = 0;
    bus.in_valid = 1'b1;
    bus.in_ch    = 5'(ch);
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && stalls < TIMEOUT) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= TIMEOUT) chk("send_timeout", 32'd1, 32'd0);
    if (ch < NCH) exp_q[ch].push_back(d);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          ch;
    logic [31:0] data;
    logic        exp_valid;
    logic        exp_drop;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int st;

    vecs[0] = '{0,  32'h1000_0001, 1'b1, 1'b0};
    vecs[1] = '{19, 32'h2000_0013, 1'b1, 1'b0};
    vecs[2] = '{20, 32'hDEAD_0014, 1'b0, 1'b1};
    vecs[3] = '{7,  32'h3000_0007, 1'b1, 1'b0};
    vecs[4] = '{31, 32'hDEAD_001F, 1'b0, 1'b1};
    vecs[5] = '{1,  32'hA5A5_5A5A, 1'b1, 1'b0};
    vecs[6] = '{19, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[7] = '{12, 32'h0000_0000, 1'b1, 1'b0};
    vecs[8] = '{12, 32'h1234_5678, 1'b1, 1'b0};
    vecs[9] = '{21, 32'hDEAD_0015, 1'b0, 1'b1};

    rst_n         = 1'b0;
    cnt_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_ch     = '0;
    bus.in_data   = '0;
    bus.out_ready = '1;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {12'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {31'd0, |bus.out_data}, 32'd0);
    chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("rst_drop_pulse", {31'd0, drop_pulse}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Table: all outputs ready, every beat lands 1 cycle after its handshake.
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].ch, vecs[i].data, st);
      chk($sformatf("vec%0d_stalls", i), st, 0);
      chk($sformatf("vec%0d_drop_pulse", i), {31'd0, drop_pulse}, {31'd0, vecs[i].exp_drop});
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_out_valid", i), {31'd0, bus.out_valid[vecs[i].ch]}, 32'd1);
        chk($sformatf("vec%0d_out_data", i), bus.out_data[vecs[i].ch*DW +: DW], vecs[i].data);
      end
    end

    // Reset mid-traffic: channel 3 held full, another beat waiting for it.
    bus.out_ready[3] = 1'b0;
    send(3, 32'h0000_0077, st);
    bus.in_valid = 1'b1;
    bus.in_ch    = 5'd3;
    bus.in_data  = 32'h0000_0079;
    @(negedge clk);
    chk("pre_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("mid_rst_out_valid", {12'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    exp_q[3].delete();
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle_ch3", {31'd0, bus.out_valid[3]}, 32'd0);
    send(3, 32'h0000_0080, st);
    chk("post_rst_latency_valid", {31'd0, bus.out_valid[3]}, 32'd1);
    chk("post_rst_latency_data", bus.out_data[3*DW +: DW], 32'h0000_0080);
    bus.out_ready[3] = 1'b1;
    @(posedge clk); #1;

    // Streaming on channel 5.
    for (int i = 1; i <= 3; i++) begin
      send(5, 32'(i * 'h11), st);
      chk($sformatf("stream%0d_stalls", i), st, 0);
      chk($sformatf("stream%0d_valid", i), {31'd0, bus.out_valid[5]}, 32'd1);
      chk($sformatf("stream%0d_data", i), bus.out_data[5*DW +: DW], 32'(i * 'h11));
    end
    @(posedge clk); #1;
    chk("stream_end_idle", {31'd0, bus.out_valid[5]}, 32'd0);

    // Channel isolation: channel 2 stalled, channel 7 unaffected.
    bus.out_ready[2] = 1'b0;
    send(2, 32'h0000_000A, st);
    fork
      send(2, 32'h0000_000B, st);
      begin
        repeat (2) @(negedge clk);
        chk("iso_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        bus.out_ready[2] = 1'b1;
      end
    join
    chk("iso_stalled", {31'd0, st != 0}, 32'd1);
    send(7, 32'h0000_000C, st);
    chk("iso_ch7_stalls", st, 0);
    chk("iso_ch7_valid", {31'd0, bus.out_valid[7]}, 32'd1);
    @(posedge clk); #1;

    // Simultaneous drain and load on channel 0.
    bus.out_ready[0] = 1'b0;
    send(0, 32'h0000_0055, st);
    bus.out_ready[0] = 1'b1;
    send(0, 32'h0000_0066, st);
    chk("drain_load_stalls", st, 0);
    chk("drain_load_valid", {31'd0, bus.out_valid[0]}, 32'd1);
    chk("drain_load_data", bus.out_data[0*DW +: DW], 32'h0000_0066);
    @(posedge clk); #1;

    // Drops and counter clear.
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(25, 32'hBAD0_0000 + 32'(i), st);
      chk($sformatf("drop%0d_pulse", i), {31'd0, drop_pulse}, 32'd1);
    end
    chk("drop_cnt_three", {16'd0, drop_cnt}, 32'd3);
    chk("drop_no_valid", {12'd0, bus.out_valid}, 32'd0);
    cnt_clr = 1'b1;
    send(25, 32'hBAD0_0003, st);
    cnt_clr = 1'b0;
    chk("clr_drop_pulse", {31'd0, drop_pulse}, 32'd1);
    chk("clr_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    @(posedge clk); #1;
    chk("clr_pulse_end", {31'd0, drop_pulse}, 32'd0);

    // Saturation: 65537 back-to-back drops from a cleared counter.
    bus.in_valid = 1'b1;
    bus.in_ch    = 5'd25;
    repeat (65537) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("sat_pulse_held", {31'd0, drop_pulse}, 32'd1);
    @(negedge clk);
    chk("sat_drop_cnt", {16'd0, drop_cnt}, 32'h0000_FFFF);

    // Everything sent must have come out.
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < NCH; k++)
      chk($sformatf("queue_empty_ch%0d", k), exp_q[k].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
